ssp_uart_fifo_ctl: RTL and testbench
====================================

Name: ssp_uart_fifo_ctl

Overview:
Parametrised FIFO controller with occupancy count, programmable threshold, receive timeout and masked interrupt generation. It is the next-generation SSP UART FIFO: the same block is instantiated once for TX and once for RX. Width, depth and timeout range are generalised. Adds overflow/underflow error flags and per-source interrupt masking. Sits between the SSP register file and the UART TX/RX shifters.

Parameters:
DW, 8, data width in bits
DEPTH, 16, FIFO entries; power of two, 4..256
TOW, 8, timeout length field width
CW, $clog2(DEPTH)+1, count width (derived, not overridable)

Ports:
Clk  in  1  system clock
Rst  in  1  reset; synchronous, active-low
Clr  in  1  FIFO clear pulse
WE  in  1  write strobe
WD  in  DW  write data
RE  in  1  read strobe
RD  out  DW  head-of-FIFO data (first-word fall-through)
Thr  in  CW  threshold level
TO_Len  in  TOW  timeout length in Tick periods; 0 = disabled
Tick  in  1  bit-time strobe from baud generator
IE  in  4  interrupt enables {TO, TH, HF, EF}
ErrClr  in  1  clears sticky Ovr/Unf
Cnt  out  CW  occupancy
EF  out  1  empty (Cnt==0)
FF  out  1  full (Cnt==DEPTH)
HF  out  1  half-full (Cnt>=DEPTH/2)
TH  out  1  threshold reached
iTO  out  1  timeout flag
Ovr  out  1  sticky write-when-full
Unf  out  1  sticky read-when-empty
IRQ  out  1  registered interrupt request

Behaviour:
- Rst low at posedge → wptr=rptr=0, Cnt=0, EF=1, FF=0, HF=0, TH=0, iTO=0, Ovr=0, Unf=0, IRQ=0, timeout counter=0. RD is don't-care while EF=1 and carries no reset value.
- Priority per cycle: Rst > Clr > WE/RE.
- Clr → pointers, Cnt and timeout counter return to 0; iTO, Ovr and Unf clear; memory contents are not cleared.
- RD = mem[rptr] combinationally. Valid whenever EF=0. A write to an empty FIFO appears on RD the cycle after WE.
- WE & !FF → mem[wptr]<=WD; wptr wraps modulo DEPTH.
- WE & FF & !RE → write dropped; Ovr<=1.
- RE & !EF → rptr advances with wrap.
- RE & EF → ignored; Unf<=1.
- WE & RE both asserted:
  - Not empty and not full: both performed, Cnt unchanged.
  - Full: both performed, Cnt stays DEPTH, no Ovr.
  - Empty: write performed, read ignored, Unf<=1, Cnt becomes 1.
- Cnt, EF, FF, HF and TH are all registered and updated in the same cycle as the pointers. Latency from a strobe to a flag is 1 clock.
- TH = (Thr!=0) && (Cnt>=Thr). Thr>DEPTH means TH never asserts.
- Timeout counter (TOW bits):
  - Reset to 0 on any accepted WE or RE, on EF=1, or when TO_Len=0.
  - Otherwise increments on Tick and saturates at TO_Len.
  - When the count equals TO_Len and TO_Len!=0, iTO<=1.
  - iTO holds until an accepted RE, Clr or Rst.
- ErrClr clears Ovr/Unf. If a new error occurs in the same cycle, the set wins.
- IRQ <= |(IE & {iTO, TH, HF, EF}), using the next-state flag values, so IRQ aligns with the flags (no extra cycle).
- Reset asserted mid-operation discards all contents; the first post-reset write lands at address 0.

Decomposition:
- Package ssp_uart_pkg:
  - IRQ bit-index localparams IRQ_EF=0, IRQ_HF=1, IRQ_TH=2, IRQ_TO=3.
  - typedef struct packed {TO, TH, HF, EF} irq_vec_t.
  - Function cnt_w(depth) returning $clog2(depth)+1.
- One sub-module: ssp_uart_fifo_ram. Single write port, asynchronous read port, DW×DEPTH, with no reset. The controller holds the pointers, counters and flags.

Test Plan:
All with DW=8, DEPTH=16.
- Reset, then write 0x01..0x10 (16 writes) → Cnt 1..16, HF set at Cnt=8, FF=1 after write 16. A 17th write of 0xAA → Ovr=1, Cnt=16. Then 16 reads return 0x01..0x10 in order, EF=1.
- Wrap: write 12, read 12, write 12 → data order preserved across pointer wrap, Cnt=12. RE on an empty FIFO → Unf=1, Cnt stays 0. ErrClr → Unf=0.
- Simultaneous: FIFO full + WE&RE → Cnt stays 16, head advances, no Ovr. FIFO empty + WE&RE (WD=0x5A) → Cnt=1, RD=0x5A, Unf=1.
- Threshold: Thr=4, IE=4'b0100 → TH and IRQ rise the cycle after the 4th write. They fall the cycle after the read that brings Cnt to 3. Thr=0 → TH stays 0.
- Timeout: TO_Len=4, one byte written, Tick every 10 clocks → iTO=1 on the 4th Tick. With IE[3]=1, IRQ=1. A read clears iTO. With TO_Len=0 there is no timeout.
- Clr issued with Cnt=7 and Ovr=1, together with a WE → Cnt=0, EF=1, Ovr=0, write ignored. Rst low mid-stream → all outputs at their reset values next cycle.

Source files
------------

// File: rtl/ssp_uart_pkg.sv
// Shared types, interrupt bit positions and sizing helper for the SSP UART FIFO.
package ssp_uart_pkg;

  localparam int IRQ_EF = 0;
  localparam int IRQ_HF = 1;
  localparam int IRQ_TH = 2;
  localparam int IRQ_TO = 3;

  typedef struct packed {
    logic to;
    logic th;
    logic hf;
    logic ef;
  } irq_vec_t;

  // Occupancy needs one bit more than the address so that "full" is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ssp_uart_fifo_ram.sv
// FIFO storage: one write port, asynchronous read port, no reset on contents.
module ssp_uart_fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_uart_fifo_ctl.sv
// FIFO controller: pointers, occupancy flags, threshold, receive timeout and masked IRQ.
module ssp_uart_fifo_ctl
  import ssp_uart_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int TOW   = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Clr,
  input  logic                    WE,
  input  logic [DW-1:0]           WD,
  input  logic                    RE,
  output logic [DW-1:0]           RD,
  input  logic [cnt_w(DEPTH)-1:0] Thr,
  input  logic [TOW-1:0]          TO_Len,
  input  logic                    Tick,
  input  logic [3:0]              IE,
  input  logic                    ErrClr,
  output logic [cnt_w(DEPTH)-1:0] Cnt,
  output logic                    EF,
  output logic                    FF,
  output logic                    HF,
  output logic                    TH,
  output logic                    iTO,
  output logic                    Ovr,
  output logic                    Unf,
  output logic                    IRQ
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH / 2);

  logic [AW-1:0]  wptr_reg, wptr_next;
  logic [AW-1:0]  rptr_reg, rptr_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [TOW-1:0] to_cnt_reg, to_cnt_next;
  logic           ef_reg, ef_next;
  logic           ff_reg, ff_next;
  logic           hf_reg, hf_next;
  logic           th_reg, th_next;
  logic           ito_reg, ito_next;
  logic           ovr_reg, ovr_next;
  logic           unf_reg, unf_next;
  logic           irq_reg, irq_next;
  logic           wr_ok, rd_ok, mem_we;
  irq_vec_t       src_next;

  ssp_uart_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (wptr_reg),
    .wdata (WD),
    .raddr (rptr_reg),
    .rdata (RD)
  );

  // A write into a full FIFO is accepted only when a read frees the head slot in the same cycle.
  assign wr_ok  = WE && (!ff_reg || RE);
  assign rd_ok  = RE && !ef_reg;
  assign mem_we = wr_ok && !Clr && Rst;

  always_comb begin
    wptr_next   = wptr_reg;
    rptr_next   = rptr_reg;
    cnt_next    = cnt_reg;
    to_cnt_next = to_cnt_reg;
    ito_next    = ito_reg;
    ovr_next    = ovr_reg;
    unf_next    = unf_reg;

    if (Clr) begin
      wptr_next   = '0;
      rptr_next   = '0;
      cnt_next    = '0;
      to_cnt_next = '0;
      ito_next    = 1'b0;
      ovr_next    = 1'b0;
      unf_next    = 1'b0;
    end else begin
      if (wr_ok) begin
        wptr_next = wptr_reg + AW'(1);
      end
      if (rd_ok) begin
        rptr_next = rptr_reg + AW'(1);
      end

      if (wr_ok && !rd_ok) begin
        cnt_next = cnt_reg + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        cnt_next = cnt_reg - CW'(1);
      end

      // A fresh error outranks ErrClr in the same cycle.
      if (WE && ff_reg && !RE) begin
        ovr_next = 1'b1;
      end else if (ErrClr) begin
        ovr_next = 1'b0;
      end

      if (RE && ef_reg) begin
        unf_next = 1'b1;
      end else if (ErrClr) begin
        unf_next = 1'b0;
      end

      if (wr_ok || rd_ok || ef_reg || (TO_Len == '0)) begin
        to_cnt_next = '0;
      end else if (to_cnt_reg >= TO_Len) begin
        to_cnt_next = TO_Len;
      end else if (Tick) begin
        to_cnt_next = to_cnt_reg + TOW'(1);
      end

      // Flag rises on the edge that brings the count to TO_Len; only a read drains it.
      if (rd_ok) begin
        ito_next = 1'b0;
      end else if ((TO_Len != '0) && (to_cnt_next == TO_Len)) begin
        ito_next = 1'b1;
      end
    end

    ef_next = (cnt_next == '0);
    ff_next = (cnt_next == CNT_FULL);
    hf_next = (cnt_next >= CNT_HALF);
    th_next = (Thr != '0) && (cnt_next >= Thr);

    src_next.to = ito_next;
    src_next.th = th_next;
    src_next.hf = hf_next;
    src_next.ef = ef_next;

    irq_next = (IE[IRQ_TO] & src_next.to) |
               (IE[IRQ_TH] & src_next.th) |
               (IE[IRQ_HF] & src_next.hf) |
               (IE[IRQ_EF] & src_next.ef);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      cnt_reg    <= '0;
      to_cnt_reg <= '0;
      ef_reg     <= 1'b1;
      ff_reg     <= 1'b0;
      hf_reg     <= 1'b0;
      th_reg     <= 1'b0;
      ito_reg    <= 1'b0;
      ovr_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      wptr_reg   <= wptr_next;
      rptr_reg   <= rptr_next;
      cnt_reg    <= cnt_next;
      to_cnt_reg <= to_cnt_next;
      ef_reg     <= ef_next;
      ff_reg     <= ff_next;
      hf_reg     <= hf_next;
      th_reg     <= th_next;
      ito_reg    <= ito_next;
      ovr_reg    <= ovr_next;
      unf_reg    <= unf_next;
      irq_reg    <= irq_next;
    end
  end

  assign Cnt = cnt_reg;
  assign EF  = ef_reg;
  assign FF  = ff_reg;
  assign HF  = hf_reg;
  assign TH  = th_reg;
  assign iTO = ito_reg;
  assign Ovr = ovr_reg;
  assign Unf = unf_reg;
  assign IRQ = irq_reg;

endmodule

// File: tb/tb_ssp_uart_fifo_ctl.sv
// Directed bench for ssp_uart_fifo_ctl with a queue-based reference model checked every cycle.
module tb_ssp_uart_fifo_ctl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TOW   = 8;
  localparam int CW    = 5;

  logic          Clk = 1'b0;
  logic          Rst, Clr, WE, RE, Tick, ErrClr;
  logic [DW-1:0] WD, RD;
  logic [CW-1:0] Thr, Cnt;
  logic [TOW-1:0] TO_Len;
  logic [3:0]    IE;
  logic          EF, FF, HF, TH, iTO, Ovr, Unf, IRQ;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: contents as a queue, plus flags derived from occupancy.
  logic [DW-1:0] q[$];
  bit m_valid = 0;
  bit m_ovr, m_unf, m_ito, m_th, m_irq;
  int m_idle;

  ssp_uart_fifo_ctl #(.DW(DW), .DEPTH(DEPTH), .TOW(TOW)) dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .WE(WE), .WD(WD), .RE(RE), .RD(RD),
    .Thr(Thr), .TO_Len(TO_Len), .Tick(Tick), .IE(IE), .ErrClr(ErrClr),
    .Cnt(Cnt), .EF(EF), .FF(FF), .HF(HF), .TH(TH), .iTO(iTO),
    .Ovr(Ovr), .Unf(Unf), .IRQ(IRQ)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_empty, was_full, acc_rd, acc_wr;
    int n;
    if (!Rst) begin
      q.delete();
      m_ovr = 0; m_unf = 0; m_ito = 0; m_idle = 0; m_th = 0; m_irq = 0;
      m_valid = 1;
      return;
    end
    if (Clr) begin
      q.delete();
      m_ovr = 0; m_unf = 0; m_ito = 0; m_idle = 0;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      acc_rd = RE && !was_empty;
      acc_wr = WE && (!was_full || acc_rd);
      if (acc_rd) void'(q.pop_front());
      if (acc_wr) q.push_back(WD);
      if (WE && was_full && !RE) m_ovr = 1; else if (ErrClr) m_ovr = 0;
      if (RE && was_empty) m_unf = 1; else if (ErrClr) m_unf = 0;
      if (acc_wr || acc_rd || was_empty || TO_Len == 0) m_idle = 0;
      else if (Tick && m_idle < int'(TO_Len)) m_idle++;
      if (acc_rd) m_ito = 0;
      else if (TO_Len != 0 && m_idle == int'(TO_Len)) m_ito = 1;
    end
    n = q.size();
    m_th  = (Thr != 0) && (n >= int'(Thr));
    m_irq = (IE[3] && m_ito) || (IE[2] && m_th) || (IE[1] && n >= DEPTH / 2) || (IE[0] && n == 0);
  endtask

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  initial forever begin
    @(negedge Clk);
    if (m_valid) begin
      chk("cnt", 32'(Cnt), 32'(q.size()));
      chk("ef",  32'(EF),  32'(q.size() == 0));
      chk("ff",  32'(FF),  32'(q.size() == DEPTH));
      chk("hf",  32'(HF),  32'(q.size() >= DEPTH / 2));
      chk("th",  32'(TH),  32'(m_th));
      chk("ito", 32'(iTO), 32'(m_ito));
      chk("ovr", 32'(Ovr), 32'(m_ovr));
      chk("unf", 32'(Unf), 32'(m_unf));
      chk("irq", 32'(IRQ), 32'(m_irq));
      if (q.size() != 0) chk("rd", 32'(RD), 32'(q[0]));
    end
  end

  task automatic cyc();
    @(negedge Clk);
    #1;
    model_step();
    @(posedge Clk);
    #2;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    WE = 1'b1; WD = d; cyc(); WE = 1'b0;
  endtask

  task automatic rd();
    RE = 1'b1; cyc(); RE = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; Clr = 1'b0; WE = 1'b0; RE = 1'b0; Tick = 1'b0; ErrClr = 1'b0;
    WD = '0; Thr = '0; TO_Len = '0; IE = '0;
    cyc(); cyc();
    Rst = 1'b1;
    $display("reset: Cnt=%0d EF=%0d IRQ=%0d", Cnt, EF, IRQ);
    chk("reset_cnt", 32'(Cnt), 32'd0);
    chk("reset_ef",  32'(EF),  32'd1);
    chk("reset_irq", 32'(IRQ), 32'd0);

    // Fill to full, overflow, drain
    for (int i = 0; i < 16; i++) begin
      wr(8'(i + 1));
      chk("fill_cnt", 32'(Cnt), 32'(i + 1));
      if (i == 6) chk("hf_below", 32'(HF), 32'd0);
      if (i == 7) chk("hf_at8", 32'(HF), 32'd1);
    end
    chk("full_ff", 32'(FF), 32'd1);
    wr(8'hAA);
    $display("overflow write: Cnt=%0d Ovr=%0d", Cnt, Ovr);
    chk("ovr_set", 32'(Ovr), 32'd1);
    chk("ovr_cnt", 32'(Cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_rd", 32'(RD), 32'(i + 1));
      rd();
    end
    chk("drain_ef", 32'(EF), 32'd1);

    // Pointer wrap
    for (int i = 0; i < 12; i++) wr(8'(8'h20 + i));
    for (int i = 0; i < 12; i++) rd();
    for (int i = 0; i < 12; i++) wr(8'(8'h40 + i));
    chk("wrap_cnt", 32'(Cnt), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("wrap_rd", 32'(RD), 32'(8'h40 + i));
      rd();
    end
    rd();
    $display("read on empty: Unf=%0d Cnt=%0d", Unf, Cnt);
    chk("unf_set", 32'(Unf), 32'd1);
    chk("unf_cnt", 32'(Cnt), 32'd0);
    ErrClr = 1'b1; cyc(); ErrClr = 1'b0;
    chk("unf_clr", 32'(Unf), 32'd0);

    // Simultaneous read and write at the boundaries
    for (int i = 0; i < 16; i++) wr(8'(8'h60 + i));
    WE = 1'b1; RE = 1'b1; WD = 8'h99; cyc(); WE = 1'b0; RE = 1'b0;
    chk("full_wr_rd_cnt", 32'(Cnt), 32'd16);
    chk("full_wr_rd_rd",  32'(RD),  32'h61);
    chk("full_wr_rd_ovr", 32'(Ovr), 32'd0);
    for (int i = 0; i < 16; i++) rd();
    WE = 1'b1; RE = 1'b1; WD = 8'h5A; cyc(); WE = 1'b0; RE = 1'b0;
    $display("empty WE&RE: Cnt=%0d RD=0x%0h Unf=%0d", Cnt, RD, Unf);
    chk("empty_wr_rd_cnt", 32'(Cnt), 32'd1);
    chk("empty_wr_rd_rd",  32'(RD),  32'h5A);
    chk("empty_wr_rd_unf", 32'(Unf), 32'd1);
    rd();
    ErrClr = 1'b1; cyc(); ErrClr = 1'b0;

    // Threshold
    Thr = 5'd4; IE = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      wr(8'(8'h80 + i));
      if (i == 2) chk("th_at3", 32'(TH), 32'd0);
    end
    chk("th_at4",  32'(TH),  32'd1);
    chk("irq_th",  32'(IRQ), 32'd1);
    rd();
    chk("th_fall",     32'(TH),  32'd0);
    chk("irq_th_fall", 32'(IRQ), 32'd0);
    Thr = 5'd0;
    wr(8'h84);
    chk("th_disabled", 32'(TH), 32'd0);
    for (int i = 0; i < 4; i++) rd();

    // Receive timeout
    TO_Len = 8'd4; IE = 4'b1000;
    wr(8'hB0);
    for (int i = 0; i < 45; i++) begin
      Tick = (i % 10 == 9);
      cyc();
      if (i == 38) chk("ito_before", 32'(iTO), 32'd0);
      if (i == 39) begin
        $display("4th tick: iTO=%0d IRQ=%0d", iTO, IRQ);
        chk("ito_4th_tick", 32'(iTO), 32'd1);
        chk("irq_ito",      32'(IRQ), 32'd1);
      end
    end
    Tick = 1'b0;
    rd();
    chk("ito_clr", 32'(iTO), 32'd0);
    TO_Len = 8'd0;
    wr(8'hB1);
    for (int i = 0; i < 45; i++) begin
      Tick = (i % 10 == 9);
      cyc();
    end
    Tick = 1'b0;
    chk("ito_disabled", 32'(iTO), 32'd0);
    rd();

    // Clear with a concurrent write
    IE = 4'b0000;
    for (int i = 0; i < 16; i++) wr(8'(8'h70 + i));
    wr(8'hAA);
    for (int i = 0; i < 9; i++) rd();
    chk("pre_clr_cnt", 32'(Cnt), 32'd7);
    Clr = 1'b1; WE = 1'b1; WD = 8'hEE; cyc(); Clr = 1'b0; WE = 1'b0;
    $display("clear: Cnt=%0d EF=%0d Ovr=%0d", Cnt, EF, Ovr);
    chk("clr_cnt", 32'(Cnt), 32'd0);
    chk("clr_ef",  32'(EF),  32'd1);
    chk("clr_ovr", 32'(Ovr), 32'd0);

    // Reset mid-stream
    IE = 4'b0001;
    wr(8'h31); wr(8'h32); wr(8'h33);
    Rst = 1'b0; WE = 1'b1; WD = 8'h34; cyc(); Rst = 1'b1; WE = 1'b0;
    $display("mid-stream reset: Cnt=%0d EF=%0d IRQ=%0d", Cnt, EF, IRQ);
    chk("rst_cnt", 32'(Cnt), 32'd0);
    chk("rst_ef",  32'(EF),  32'd1);
    chk("rst_irq", 32'(IRQ), 32'd0);
    cyc();
    chk("post_rst_irq", 32'(IRQ), 32'd1);
    wr(8'hC3);
    chk("post_rst_rd",  32'(RD),  32'hC3);
    chk("post_rst_cnt", 32'(Cnt), 32'd1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
